// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit machine words and
// streams them into instruction memory at consecutive word addresses.
module mips_instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        fn;
  logic [5:0]        op;
  logic [31:0]       enc;
  logic              legal;
  logic              accept;
  logic              at_top;

  // Function code for R-type mnemonics, opcode for the rest
  always_comb begin
    fn = 6'h00;
    op = 6'h00;
    case (in_mnem)
      5'd0:  fn = 6'h00;
      5'd1:  fn = 6'h02;
      5'd2:  fn = 6'h03;
      5'd3:  fn = 6'h06;
      5'd4:  fn = 6'h07;
      5'd5:  fn = 6'h20;
      5'd6:  fn = 6'h21;
      5'd7:  fn = 6'h22;
      5'd8:  fn = 6'h24;
      5'd9:  fn = 6'h25;
      5'd10: fn = 6'h27;
      5'd11: fn = 6'h2A;
      5'd12: fn = 6'h2B;
      5'd13: fn = 6'h08;
      5'd14: fn = 6'h0C;
      5'd15: op = 6'h08;
      5'd16: op = 6'h09;
      5'd17: op = 6'h0C;
      5'd18: op = 6'h0D;
      5'd19: op = 6'h0A;
      5'd20: op = 6'h23;
      5'd21: op = 6'h2B;
      5'd22: op = 6'h28;
      5'd23: op = 6'h04;
      5'd24: op = 6'h05;
      5'd25: op = 6'h01;
      5'd26: op = 6'h02;
      5'd27: op = 6'h03;
      default: ;
    endcase
  end

  // Field packing per instruction class; fields a class ignores are zeroed
  always_comb begin
    legal = 1'b1;
    enc   = '0;
    if (in_mnem <= 5'd2)       enc = {6'h00, 5'd0, in_rt, in_rd, in_shamt, fn};
    else if (in_mnem <= 5'd12) enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, fn};
    else if (in_mnem == 5'd13) enc = {6'h00, in_rs, 15'd0, fn};
    else if (in_mnem == 5'd14) enc = {26'd0, fn};
    else if (in_mnem <= 5'd24) enc = {op, in_rs, in_rt, in_imm};
    else if (in_mnem == 5'd25) enc = {op, in_rs, 5'd0, in_imm};
    else if (in_mnem <= 5'd27) enc = {op, in_target};
    else                       legal = 1'b0;
  end

  // start has priority over any request presented in the same cycle
  assign in_ready = (state == LOAD) && !full && !start;
  assign accept   = in_valid && in_ready;
  assign at_top   = (addr == TOP_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= BASE_WORD;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state      <= LOAD;
        addr       <= BASE_WORD;
        word_count <= '0;
        err        <= 1'b0;
        full       <= 1'b0;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= addr;
          imem_wdata <= enc;
          word_count <= word_count + CNT_W'(1);
          // The last word of memory never wraps the address back to 0
          if (!at_top) addr <= addr + ADDR_W'(1);
          else if (!in_last) full <= 1'b1;
        end else begin
          err <= 1'b1;
        end
        if (in_last || (legal && at_top)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed program loads plus randomized
// request streams checked against a table-driven encoding model.
module tb_mips_instr_encoder;

  localparam int unsigned TOP = 1023;

  localparam int FUNC_T [15] = '{'h00, 'h02, 'h03, 'h06, 'h07, 'h20, 'h21, 'h22,
                                 'h24, 'h25, 'h27, 'h2A, 'h2B, 'h08, 'h0C};
  localparam int OP_T [13] = '{'h08, 'h09, 'h0C, 'h0D, 'h0A, 'h23, 'h2B, 'h28,
                               'h04, 'h05, 'h01, 'h02, 'h03};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_last;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, imem_we, busy, done, full, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_count;

  logic        s_start, s_valid, s_last;
  logic        s_ready, s_we, s_busy, s_done, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference state: 0 idle, 1 loading, 2 done
  int m_state, m_addr, m_cnt, m_err, m_full;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_mnem(in_mnem), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .full(full), .err(err),
    .word_count(word_count)
  );

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
    .in_ready(s_ready), .in_last(s_last), .in_mnem(in_mnem), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .imem_we(s_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .busy(s_busy), .done(s_done), .full(s_full), .err(s_err),
    .word_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encoding from the instruction tables: which fields each class keeps
  function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt,
                                          input int rd, input int sh, input int imm,
                                          input int tg);
    logic [31:0] w;
    bit krs, krt, ksh;
    w = 32'd0;
    if (m < 15) begin
      krs = (m > 2) && (m != 14);
      krt = (m < 13);
      ksh = (m <= 2);
      w = 32'(FUNC_T[m]);
      if (krs) w = w | (32'(rs & 31) << 21);
      if (krt) w = w | (32'(rt & 31) << 16) | (32'(rd & 31) << 11);
      if (ksh) w = w | (32'(sh & 31) << 6);
    end else if (m < 26) begin
      w = (32'(OP_T[m-15]) << 26) | (32'(rs & 31) << 21) | 32'(imm & 'hFFFF);
      if (m != 25) w = w | (32'(rt & 31) << 16);
    end else if (m < 28) begin
      w = (32'(OP_T[m-15]) << 26) | 32'(tg & 'h3FFFFFF);
    end
    return w;
  endfunction

  // One clock of stimulus on the main instance, then compare against the model
  task automatic step(input bit s, input bit v, input bit last, input int mn,
                      input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tg);
    bit acc, xwe;
    int xaddr;
    logic [31:0] xwd;
    start = s; in_valid = v; in_last = last;
    in_mnem = 5'(mn); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tg);
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_state == 1 && !s));
    acc = v && (m_state == 1) && !s;
    xwe = 1'b0; xaddr = 0; xwd = 32'd0;
    if (s) begin
      m_state = 1; m_addr = 0; m_cnt = 0; m_err = 0; m_full = 0;
    end else if (acc) begin
      if (mn >= 28) begin
        m_err = 1;
        if (last) m_state = 2;
      end else begin
        xwe = 1'b1; xaddr = m_addr;
        xwd = ref_enc(mn, rs, rt, rd, sh, imm, tg);
        m_cnt++;
        if (last) m_state = 2;
        else if (m_addr == TOP) begin m_full = 1; m_state = 2; end
        if (m_addr != TOP) m_addr++;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("imem_we", 32'(imem_we), 32'(xwe));
    if (xwe) begin
      chk("imem_addr", 32'(imem_addr), 32'(xaddr));
      chk("imem_wdata", imem_wdata, xwd);
    end
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("full", 32'(full), 32'(m_full));
    chk("err", 32'(err), 32'(m_err));
    chk("word_count", 32'(word_count), 32'(m_cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cnt"}, 32'(word_count), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    bit rs_start, rs_valid, rs_last;
    int mn;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0;
    m_state = 0; m_addr = 0; m_cnt = 0; m_err = 0; m_full = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add with in_last
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 1, 2, 3, 0, 0, 0);
    chk("tp_add", imem_wdata, 32'h00221820);

    // Back-to-back stream
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 15, 0, 8, 0, 0, 'hFFFF, 0);
    chk("tp_addi", imem_wdata, 32'h2008FFFF);
    step(0, 1, 0, 0, 0, 1, 2, 4, 0, 0);
    chk("tp_sll", imem_wdata, 32'h00011100);
    step(0, 1, 1, 14, 3, 3, 3, 3, 0, 0);
    chk("tp_syscall", imem_wdata, 32'h0000000C);

    // Field forcing and an illegal code in mid-stream
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 26, 0, 0, 0, 0, 0, 'h0100000);
    chk("tp_j", imem_wdata, 32'h08100000);
    step(0, 1, 0, 25, 4, 7, 0, 0, 'hFFFE, 0);
    chk("tp_bltz", imem_wdata, 32'h0480FFFE);
    step(0, 1, 0, 21, 29, 5, 0, 0, 8, 0);
    chk("tp_sw", imem_wdata, 32'hAFA50008);
    step(0, 1, 0, 30, 1, 1, 1, 1, 1, 1);
    step(0, 1, 1, 18, 2, 3, 0, 0, 'h1234, 0);
    chk("tp_after_illegal_addr", 32'(imem_addr), 32'd3);

    // start together with a valid request: nothing accepted that cycle
    step(1, 1, 0, 5, 1, 2, 3, 0, 0, 0);

    // Randomized stream with occasional restarts and illegal codes
    for (int i = 0; i < 400; i++) begin
      rs_start = (m_state != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      rs_valid = ($urandom_range(0, 3) != 0);
      rs_last  = ($urandom_range(0, 19) == 0);
      mn = int'($urandom_range(0, 31));
      step(rs_start, rs_valid, rs_last, mn, int'($urandom), int'($urandom),
           int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    end

    // Capacity exhaustion on the 4-word instance
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    in_mnem = 5'd5; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_shamt = 5'd0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      #1;
      chk("small_ready", 32'(s_ready), 32'(k < 4));
      @(posedge clk);
      #1;
      chk("small_we", 32'(s_we), 32'(k < 4));
      if (k < 4) begin
        chk("small_addr", 32'(s_addr), 32'(k));
        chk("small_wdata", s_wdata, 32'h00221820);
      end
      chk("small_full", 32'(s_full), 32'(k >= 3));
      chk("small_done", 32'(s_done), 32'(k >= 3));
      chk("small_cnt", 32'(s_cnt), 32'((k < 4) ? k + 1 : 4));
    end
    s_valid = 1'b0;

    // Asynchronous reset in the middle of a stream
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 6, 4, 5, 6, 0, 0, 0);
    in_valid = 1'b1; in_last = 1'b0; in_mnem = 5'd7;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk_all_zero("midrst_post");
    rst_n = 1'b1;
    in_valid = 1'b0;
    m_state = 0; m_addr = 0; m_cnt = 0; m_err = 0; m_full = 0;
    step(0, 1, 1, 5, 1, 2, 3, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the control decoder: turns symbolic instruction requests (mnemonic code plus operand fields) into 32-bit MIPS machine words.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used by the program-load/self-test path to build programs in IMEM before the single-cycle CPU runs them.
- Covers exactly the instruction set the CPU decodes.

Parameters:
ADDR_W, 10, IMEM word-address width; capacity is 2^ADDR_W words.
BASE_ADDR, 0, first IMEM word address written after start.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a new load session.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request this cycle.
in_last  in  1  request is the final instruction of the program.
in_mnem  in  5  mnemonic code (table below).
in_rs  in  5  rs field.
in_rt  in  5  rt field.
in_rd  in  5  rd field.
in_shamt  in  5  shift amount.
in_imm  in  16  immediate / branch offset.
in_target  in  26  jump target field.
imem_we  out  1  IMEM write strobe, one cycle per word.
imem_addr  out  ADDR_W  IMEM write address.
imem_wdata  out  32  encoded instruction.
busy  out  1  state is LOAD.
done  out  1  state is DONE.
full  out  1  capacity exhausted before in_last.
err  out  1  sticky: an illegal mnemonic was received this session.
word_count  out  ADDR_W+1  words written this session.

Behaviour:
- Mnemonic codes, R-type (op 0, listed as code=func): 0 sll=00, 1 srl=02, 2 sra=03, 3 srlv=06, 4 srav=07, 5 add=20, 6 addu=21, 7 sub=22, 8 and=24, 9 or=25, 10 nor=27, 11 slt=2A, 12 sltu=2B, 13 jr=08, 14 syscall=0C (func values hex).
- Mnemonic codes, other types (listed as code=op): 15 addi=08, 16 addiu=09, 17 andi=0C, 18 ori=0D, 19 slti=0A, 20 lw=23, 21 sw=2B, 22 sb=28, 23 beq=04, 24 bne=05, 25 bltz=01, 26 j=02, 27 jal=03 (op values hex).
- Codes 28-31 are illegal.
- Field packing: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0]. I-type uses imm[15:0]; J-type uses target[25:0].
- Unused fields are forced to 0:
  - sll/srl/sra: rs=0.
  - Variable shifts and the other R ALU ops: shamt=0.
  - jr: rt=rd=shamt=0.
  - syscall: only func is set.
  - bltz: rt=0.
- States: IDLE, LOAD, DONE. Reset leads to IDLE.
  - IDLE: in_ready=0. start moves to LOAD.
  - LOAD: in_ready = ~full_pending. Accept when in_valid & in_ready.
  - DONE: in_ready=0. start moves to LOAD.
- start in any state: address := BASE_ADDR, word_count := 0, err := 0, full := 0, state := LOAD. In that same cycle start wins: in_ready=0 and nothing is accepted.
- Legal accept: next cycle imem_we=1, imem_addr = current address, imem_wdata = encoding. Latency is exactly 1 cycle. Address and word_count increment by 1.
- Throughput: one word per cycle.
- Illegal accept: no write, address unchanged, err set. The in_last on an illegal request is still honoured.
- Accept with in_last=1: state moves to DONE in the cycle the final write is issued.
- Address wrap: when the accepted word targets address 2^ADDR_W-1 without in_last, that word is written, then full=1 and state moves to DONE. The address never wraps to 0.
- A write already registered when start arrives still completes on the next cycle at its old address.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, full=0, err=0, word_count=0, in_ready=0.
- Asynchronous reset mid-session aborts immediately, with no trailing write.

Test Plan:
- Start, then add rs=1 rt=2 rd=3 with in_last -> one cycle later imem_we=1, addr 0, wdata 0x00221820; done=1, word_count=1.
- Back-to-back stream: addi rt=8 rs=0 imm=FFFF; sll rd=2 rt=1 shamt=4; syscall -> wdata 0x2008FFFF, 0x00011100, 0x0000000C at addrs 0,1,2 on consecutive cycles.
- Field forcing: j target=0x0100000 -> 0x08100000; bltz rs=4 rt=7 imm=FFFE -> 0x0480FFFE (rt ignored); sw rs=29 rt=5 imm=8 -> 0xAFA50008.
- Illegal code 30 between two legal requests -> no write for it, err=1, the next legal word lands at the following address (no gap).
- ADDR_W=2, five requests without in_last -> writes at addrs 0..3, then full=1, done=1, in_ready=0, fifth request not accepted.
- start asserted together with in_valid, and rst_n pulled low mid-stream -> first request not accepted; after reset all outputs are 0 and no write appears.
